hd6309_bus_bridge: RTL and testbench



---
 rtl/hd6309_pkg.sv | 28 ++
 rtl/hd6309_edge_sync.sv | 41 ++++
 rtl/hd6309_bus_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_hd6309_bus_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd6309_pkg.sv
// ---------------------------------------------------------------------------
// hd6309_pkg
// Shared definitions for the HD6309 pin-bus to SoC memory-bus bridge.
//   state_t        : bridge FSM states (IDLE, WDAT, REQ, HOLD)
//   DUMMY_ADDR     : address the CPU drives on a dead (dummy) bus cycle
//   ERR_RDATA      : read value presented on dummy or timed-out cycles
//   is_dummy_cycle : classifies a CPU cycle as a dummy cycle
// ---------------------------------------------------------------------------
package hd6309_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WDAT = 2'd1,
    ST_REQ  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [15:0] DUMMY_ADDR = 16'hFFFF;
  localparam logic [7:0]  ERR_RDATA  = 8'hFF;

  // A dummy cycle is a read of 16'hFFFF that is not a vector fetch.
  function automatic logic is_dummy_cycle(input logic [15:0] addr,
                                          input logic        rw,
                                          input logic        bs);
    return (addr == DUMMY_ADDR) && rw && !bs;
  endfunction

endpackage

// File: rtl/hd6309_edge_sync.sv
// ---------------------------------------------------------------------------
// hd6309_edge_sync
// Brings one asynchronous CPU phase clock into the clk domain and produces
// single-cycle rise/fall pulses.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   i_async : asynchronous input (E or Q)
//   o_rise  : one-cycle pulse when the synchronized level goes 0->1
//   o_fall  : one-cycle pulse when the synchronized level goes 1->0
// ---------------------------------------------------------------------------
module hd6309_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  // r_sync[STAGES-1] is the synchronizer output, r_sync[STAGES] its
  // previous value; edges compare the two.
  logic [STAGES:0] r_sync;
  // Tracks which stages hold real samples since reset, so a level that was
  // already high when reset was released is not mistaken for an edge.
  logic [STAGES:0] r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_valid <= '0;
    end else begin
      r_sync  <= {r_sync[STAGES-1:0], i_async};
      r_valid <= {r_valid[STAGES-1:0], 1'b1};
    end
  end

  assign o_rise = r_valid[STAGES] &  r_sync[STAGES-1] & ~r_sync[STAGES];
  assign o_fall = r_valid[STAGES] & ~r_sync[STAGES-1] &  r_sync[STAGES];

endmodule

// File: rtl/hd6309_bus_bridge.sv
// ---------------------------------------------------------------------------
// hd6309_bus_bridge
// Turns the HD6309 pin-level bus into single-beat requests on the internal
// memory bus, returns read data to the CPU and stretches the CPU cycle via
// MRDY while memory is busy. A timeout bounds the stretch.
//   clk, rst_n          : system clock, synchronous active-low reset
//   i_cpu_e, i_cpu_q    : CPU phase clocks (asynchronous)
//   i_cpu_rw            : 1 = read
//   i_cpu_ba, i_cpu_bs  : CPU bus status
//   i_cpu_addr/_wdata   : CPU address and data bus
//   o_cpu_rdata         : read data toward the CPU
//   o_cpu_mrdy          : 0 = stretch the current CPU cycle
//   o_mem_req/_we/_addr/_wdata : memory request (held until i_mem_ack)
//   i_mem_ack, i_mem_rdata     : one-cycle completion strobe and read data
//   o_vec_fetch         : pulse at the start of a vector fetch cycle
//   o_bus_err           : pulse when a cycle is force-completed by timeout
// ---------------------------------------------------------------------------
module hd6309_bus_bridge
  import hd6309_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 400,
  parameter bit DROP_DUMMY  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_e,
  input  logic        i_cpu_q,
  input  logic        i_cpu_rw,
  input  logic        i_cpu_ba,
  input  logic        i_cpu_bs,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_mrdy,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_vec_fetch,
  output logic        o_bus_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);

  logic w_e_rise, w_e_fall, w_q_rise, w_q_fall;

  hd6309_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_e (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_cpu_e),
    .o_rise  (w_e_rise),
    .o_fall  (w_e_fall)
  );

  hd6309_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_cpu_q),
    .o_rise  (w_q_rise),
    .o_fall  (w_q_fall)
  );

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_orphan, w_orphan;
  logic [15:0]      r_addr, w_addr;
  logic             r_rw, w_rw;
  logic [7:0]       r_wdata, w_wdata;
  logic             r_e_up, w_e_up;
  logic             r_e_done, w_e_done;
  logic             r_mem_req, w_mem_req;
  logic             r_mem_we, w_mem_we;
  logic [15:0]      r_mem_addr, w_mem_addr;
  logic [7:0]       r_mem_wdata, w_mem_wdata;
  logic [7:0]       r_rdata, w_rdata;
  logic             r_mrdy, w_mrdy;
  logic             r_vec, w_vec;
  logic             r_err, w_err;

  logic w_e_end;
  logic w_timeout;
  logic w_ack_live;

  // An E fall only ends the cycle if E rose during this cycle.
  assign w_e_end    = w_e_fall & r_e_up;
  assign w_timeout  = (r_cnt == CNT_LAST);
  // Only an ack for our own outstanding request completes the CPU cycle.
  assign w_ack_live = i_mem_ack & r_mem_req & ~r_orphan;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_orphan    <= 1'b0;
      r_addr      <= '0;
      r_rw        <= 1'b1;
      r_wdata     <= '0;
      r_e_up      <= 1'b0;
      r_e_done    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= ERR_RDATA;
      r_mrdy      <= 1'b1;
      r_vec       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_orphan    <= w_orphan;
      r_addr      <= w_addr;
      r_rw        <= w_rw;
      r_wdata     <= w_wdata;
      r_e_up      <= w_e_up;
      r_e_done    <= w_e_done;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_rdata     <= w_rdata;
      r_mrdy      <= w_mrdy;
      r_vec       <= w_vec;
      r_err       <= w_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_orphan    = r_orphan;
    w_addr      = r_addr;
    w_rw        = r_rw;
    w_wdata     = r_wdata;
    w_e_up      = r_e_up;
    w_e_done    = r_e_done;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_rdata     = r_rdata;
    w_mrdy      = r_mrdy;
    w_vec       = 1'b0;
    w_err       = 1'b0;

    if (r_state != ST_IDLE) begin
      if (r_cnt != CNT_MAX) begin
        w_cnt = r_cnt + CNT_W'(1);
      end
      if (w_e_rise) begin
        w_e_up = 1'b1;
      end
      // Remember an E fall seen before completion (CPU ignored MRDY) so the
      // cycle returns straight to IDLE once it completes.
      if (w_e_end) begin
        w_e_done = 1'b1;
      end
    end

    // A request abandoned by timeout stays on the bus until memory acks it;
    // that ack carries nothing for the CPU and simply retires the request.
    if (r_orphan && i_mem_ack) begin
      w_orphan  = 1'b0;
      w_mem_req = 1'b0;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (w_q_rise && !i_cpu_ba) begin
          w_addr   = i_cpu_addr;
          w_rw     = i_cpu_rw;
          w_cnt    = '0;
          w_e_up   = 1'b0;
          w_e_done = 1'b0;
          w_vec    = i_cpu_bs;
          if (DROP_DUMMY && is_dummy_cycle(i_cpu_addr, i_cpu_rw, i_cpu_bs)) begin
            w_rdata = ERR_RDATA;
            w_mrdy  = 1'b1;
            w_state = ST_HOLD;
          end else begin
            w_mrdy  = 1'b0;
            w_state = i_cpu_rw ? ST_REQ : ST_WDAT;
          end
        end
      end

      ST_WDAT: begin
        if (w_timeout) begin
          w_err   = 1'b1;
          w_rdata = ERR_RDATA;
          w_mrdy  = 1'b1;
          w_state = (r_e_done || w_e_end) ? ST_IDLE : ST_HOLD;
        end else if (w_q_fall) begin
          w_wdata = i_cpu_wdata;
          w_state = ST_REQ;
        end
      end

      ST_REQ: begin
        if (w_ack_live) begin
          w_mem_req = 1'b0;
          if (r_rw) begin
            w_rdata = i_mem_rdata;
          end
          w_mrdy  = 1'b1;
          w_state = (r_e_done || w_e_end) ? ST_IDLE : ST_HOLD;
        end else if (w_timeout) begin
          w_err   = 1'b1;
          w_rdata = ERR_RDATA;
          w_mrdy  = 1'b1;
          w_state = (r_e_done || w_e_end) ? ST_IDLE : ST_HOLD;
          if (r_mem_req && !r_orphan) begin
            w_orphan = 1'b1;
          end
        end else if (!r_mem_req && !r_orphan) begin
          // Issue only once the bus is free of any orphaned request.
          w_mem_req   = 1'b1;
          w_mem_we    = ~r_rw;
          w_mem_addr  = r_addr;
          w_mem_wdata = r_wdata;
        end
      end

      ST_HOLD: begin
        if (w_e_end) begin
          w_state = ST_IDLE;
        end
      end
    endcase
  end

  assign o_cpu_rdata = r_rdata;
  assign o_cpu_mrdy  = r_mrdy;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_vec_fetch = r_vec;
  assign o_bus_err   = r_err;

endmodule

// File: tb/tb_hd6309_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_hd6309_bus_bridge
// Drives HD6309-style bus cycles (E/Q, address, R/W, BA/BS) into the bridge,
// answers memory requests from a behavioural memory, and compares what the
// CPU and the memory bus see against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_hd6309_bus_bridge;

  localparam int TIMEOUT  = 400;
  localparam int MRDY_LAT = 3;
  localparam int BOUND    = 3 * TIMEOUT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpuE = 1'b0;
  logic        cpuQ = 1'b0;
  logic        cpuRw = 1'b1;
  logic        cpuBa = 1'b0;
  logic        cpuBs = 1'b0;
  logic [15:0] cpuAddr = 16'h0000;
  logic [7:0]  cpuWdata = 8'h00;
  logic [7:0]  cpuRdata;
  logic        cpuMrdy;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [7:0]  memWdata;
  logic        memAck = 1'b0;
  logic [7:0]  memRdata = 8'h00;
  logic        vecFetch;
  logic        busErr;

  hd6309_bus_bridge #(
    .SYNC_STAGES (2),
    .TIMEOUT     (TIMEOUT),
    .DROP_DUMMY  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cpu_e     (cpuE),
    .i_cpu_q     (cpuQ),
    .i_cpu_rw    (cpuRw),
    .i_cpu_ba    (cpuBa),
    .i_cpu_bs    (cpuBs),
    .i_cpu_addr  (cpuAddr),
    .i_cpu_wdata (cpuWdata),
    .o_cpu_rdata (cpuRdata),
    .o_cpu_mrdy  (cpuMrdy),
    .o_mem_req   (memReq),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .i_mem_ack   (memAck),
    .i_mem_rdata (memRdata),
    .o_vec_fetch (vecFetch),
    .o_bus_err   (busErr)
  );

  // 10 ns system clock; one CPU E cycle spans at least 20 of these.
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int clkCnt = 0;

  // Free-running count of rising clk edges, used to time-stamp events.
  always @(posedge clk) clkCnt <= clkCnt + 1;

  // Memory contents served to the bridge, and the model's own copy.
  logic [7:0]  memArr [0:65535];
  logic [7:0]  refMem [0:65535];

  // Log of requests seen on the memory bus and of ack time stamps.
  logic [15:0] reqAddrQ[$];
  logic        reqWeQ[$];
  logic [7:0]  reqWdataQ[$];
  int          reqClkQ[$];
  int          ackHist[$];
  int          delayQ[$];
  int          defaultDelay = 3;
  bit          injectAck = 1'b0;
  int          lastAckClk = 0;

  logic [15:0] rspAddr;
  logic        rspWe;
  logic [7:0]  rspWdata;
  int          rspDelay;
  bit          rspAborted;

  // Memory responder: logs each new request and acks it after a chosen
  // number of clocks. A request that vanishes before its ack (reset) is
  // dropped. It can also inject an unsolicited ack while the bus is quiet.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && memReq) begin
        rspAddr  = memAddr;
        rspWe    = memWe;
        rspWdata = memWdata;
        reqAddrQ.push_back(rspAddr);
        reqWeQ.push_back(rspWe);
        reqWdataQ.push_back(rspWdata);
        reqClkQ.push_back(clkCnt);
        rspDelay   = (delayQ.size() > 0) ? delayQ.pop_front() : defaultDelay;
        rspAborted = 1'b0;
        for (int k = 1; k < rspDelay && !rspAborted; k++) begin
          @(negedge clk);
          if (!memReq) rspAborted = 1'b1;
        end
        if (!rspAborted) begin
          if (rspWe) memArr[rspAddr] = rspWdata;
          memRdata   = rspWe ? 8'h00 : memArr[rspAddr];
          memAck     = 1'b1;
          lastAckClk = clkCnt + 1;
          ackHist.push_back(lastAckClk);
          @(negedge clk);
          memAck = 1'b0;
        end
      end else if (injectAck && !memReq) begin
        memRdata = 8'h5A;
        memAck   = 1'b1;
        @(negedge clk);
        memAck    = 1'b0;
        injectAck = 1'b0;
      end
    end
  end

  int vecCnt = 0;
  int errCnt = 0;
  int lowCnt = 0;
  int lastMrdyFall = 0;
  int lastMrdyRise = 0;
  logic prevMrdy = 1'b1;

  // Pulse counters and MRDY edge time stamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (vecFetch) vecCnt <= vecCnt + 1;
    if (busErr) errCnt <= errCnt + 1;
    if (!cpuMrdy) lowCnt <= lowCnt + 1;
    if (!cpuMrdy && prevMrdy) lastMrdyFall <= clkCnt;
    if (cpuMrdy && !prevMrdy) lastMrdyRise <= clkCnt;
    prevMrdy <= cpuMrdy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  int          obsReqN, obsReqClk, obsVec, obsErr, obsLow, obsFallLat;
  int          obsRiseClk, obsWaited, qClk;
  logic [15:0] obsReqAddr;
  logic        obsReqWe;
  logic [7:0]  obsReqWdata, obsRdata;

  // One CPU bus cycle: Q rise, E rise, Q fall, then E fall once MRDY is
  // high (the CPU stretches E while MRDY is low). Observations are stored
  // for the model to judge.
  task automatic applyStimulus(input logic [15:0] a, input logic rw,
                               input logic bs, input logic ba,
                               input logic [7:0] wd);
    int sVec, sErr, sLow;
    @(negedge clk);
    reqAddrQ.delete();
    reqWeQ.delete();
    reqWdataQ.delete();
    reqClkQ.delete();
    cpuAddr = a;
    cpuRw = rw;
    cpuBs = bs;
    cpuBa = ba;
    cpuWdata = wd;
    sVec = vecCnt;
    sErr = errCnt;
    sLow = lowCnt;
    repeat (2) @(negedge clk);
    cpuQ = 1'b1;
    qClk = clkCnt;
    repeat (5) @(negedge clk);
    cpuE = 1'b1;
    repeat (5) @(negedge clk);
    cpuQ = 1'b0;
    repeat (5) @(negedge clk);
    obsWaited = 0;
    while (!cpuMrdy && obsWaited < BOUND) begin
      @(negedge clk);
      obsWaited++;
    end
    obsRdata = cpuRdata;
    cpuE = 1'b0;
    repeat (4) @(negedge clk);
    obsReqN = reqAddrQ.size();
    if (obsReqN > 0) begin
      obsReqAddr  = reqAddrQ[0];
      obsReqWe    = reqWeQ[0];
      obsReqWdata = reqWdataQ[0];
      obsReqClk   = reqClkQ[0];
    end
    obsVec     = vecCnt - sVec;
    obsErr     = errCnt - sErr;
    obsLow     = lowCnt - sLow;
    obsFallLat = lastMrdyFall - qClk;
    obsRiseClk = lastMrdyRise;
  endtask

  logic [7:0] lastExpRdata = 8'hFF;

  // Reference model for one cycle: decides from the cycle's type what the
  // memory bus and the CPU should have seen, then compares.
  task automatic runCycle(input string name, input logic [15:0] a,
                          input logic rw, input logic bs, input logic ba,
                          input logic [7:0] wd, input bit expTimeout);
    bit dummy, expReq;
    logic [7:0] expRdata;
    int riseLat;
    dummy  = (a == 16'hFFFF) && rw && !bs;
    expReq = !ba && !dummy;
    applyStimulus(a, rw, bs, ba, wd);
    checkOutput({name, ":bound"}, int'(obsWaited >= BOUND), 0);
    checkOutput({name, ":reqN"}, obsReqN, expReq ? 1 : 0);
    if (expReq && obsReqN > 0) begin
      checkOutput({name, ":addr"}, obsReqAddr, a);
      checkOutput({name, ":we"}, obsReqWe, !rw);
      if (!rw) checkOutput({name, ":wdata"}, obsReqWdata, wd);
    end
    checkOutput({name, ":vec"}, obsVec, (!ba && bs) ? 1 : 0);
    checkOutput({name, ":err"}, obsErr, expTimeout ? 1 : 0);
    if (ba) expRdata = lastExpRdata;
    else if (dummy || expTimeout) expRdata = 8'hFF;
    else if (rw) expRdata = refMem[a];
    else expRdata = lastExpRdata;
    checkOutput({name, ":rdata"}, obsRdata, expRdata);
    lastExpRdata = expRdata;
    if (expReq) checkOutput({name, ":mrdyFall"}, obsFallLat, MRDY_LAT);
    if (ba) checkOutput({name, ":mrdyLow"}, obsLow, 0);
    if (expReq && !expTimeout) checkOutput({name, ":mrdyRise"}, obsRiseClk, lastAckClk);
    if (expTimeout) begin
      riseLat = obsRiseClk - qClk;
      checkOutput({name, ":toLat"},
                  int'(riseLat >= MRDY_LAT + TIMEOUT - 1 && riseLat <= MRDY_LAT + TIMEOUT + 1), 1);
    end
    if (expReq && !rw && !expTimeout) refMem[a] = wd;
  endtask

  int lateAck;
  int waitCnt;

  initial begin
    logic [15:0] a;
    logic        rw, bs, ba;
    logic [7:0]  wd;

    for (int i = 0; i < 65536; i++) begin
      memArr[i] = 8'($urandom);
      refMem[i] = memArr[i];
    end
    memArr[16'h1234] = 8'hA5; refMem[16'h1234] = 8'hA5;
    memArr[16'h2000] = 8'h11; refMem[16'h2000] = 8'h11;
    memArr[16'h2001] = 8'h22; refMem[16'h2001] = 8'h22;

    // Reset state.
    repeat (4) @(negedge clk);
    checkOutput("rst:memReq", memReq, 0);
    checkOutput("rst:memWe", memWe, 0);
    checkOutput("rst:memAddr", memAddr, 16'h0000);
    checkOutput("rst:memWdata", memWdata, 8'h00);
    checkOutput("rst:mrdy", cpuMrdy, 1);
    checkOutput("rst:rdata", cpuRdata, 8'hFF);
    checkOutput("rst:vec", vecFetch, 0);
    checkOutput("rst:err", busErr, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed cycles from the test plan.
    defaultDelay = 5;
    runCycle("rdA5", 16'h1234, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    defaultDelay = 1;
    runCycle("wr3C", 16'h8000, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
    defaultDelay = 2;
    runCycle("rdBack", 16'h8000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    runCycle("dummy", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    runCycle("vector", 16'hFFFE, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      runCycle("baHigh", 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 1'b0);
    end

    // Unsolicited ack while idle must be ignored.
    injectAck = 1'b1;
    waitCnt = 0;
    while (injectAck && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("spurAck:sent", injectAck, 0);
    runCycle("afterSpur", 16'h0042, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Timeout with a late ack, then a new cycle that must wait for it.
    delayQ.push_back(TIMEOUT + 60);
    defaultDelay = 3;
    runCycle("timeout", 16'h2000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    runCycle("afterOrph", 16'h2001, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    lateAck = (ackHist.size() >= 2) ? ackHist[ackHist.size() - 2] : 0;
    checkOutput("orphan:reqAfterAck", int'(obsReqN > 0 && obsReqClk > lateAck), 1);

    // Reset while a read request is outstanding.
    delayQ.push_back(60);
    @(negedge clk);
    reqAddrQ.delete();
    reqWeQ.delete();
    reqWdataQ.delete();
    reqClkQ.delete();
    cpuAddr = 16'h4321;
    cpuRw = 1'b1;
    cpuBs = 1'b0;
    cpuBa = 1'b0;
    repeat (2) @(negedge clk);
    cpuQ = 1'b1;
    waitCnt = 0;
    while (!memReq && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rstMid:reqSeen", memReq, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstMid:memReq", memReq, 0);
    checkOutput("rstMid:mrdy", cpuMrdy, 1);
    checkOutput("rstMid:rdata", cpuRdata, 8'hFF);
    cpuE = 1'b1;
    repeat (5) @(negedge clk);
    cpuQ = 1'b0;
    repeat (5) @(negedge clk);
    cpuE = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rstMid:noNewReq", reqAddrQ.size(), 1);
    lastExpRdata = 8'hFF;
    runCycle("afterRst", 16'h1234, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized cycles.
    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rw = 1'($urandom);
      bs = ($urandom_range(0, 3) == 0);
      ba = ($urandom_range(0, 5) == 0);
      wd = 8'($urandom);
      defaultDelay = $urandom_range(1, 8);
      runCycle("rand", a, rw, bs, ba, wd, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
